// File: rtl/uart_cmd_parser.sv
// UART command-frame parser: assembles HDR/OP/ADDR/DATA/CHK frames, issues a
// one-cycle write or read strobe to the register block and returns a single
// response byte (ACK, read data or NAK) over a valid/ready TX handshake.
module uart_cmd_parser #(
    parameter logic [15:0] TIMEOUT_CYC = 16'd50000,
    parameter logic [7:0]  HDR         = 8'hA5,
    parameter logic [7:0]  ACK         = 8'h06,
    parameter logic [7:0]  NAK         = 8'h15
) (
    input  logic       clk_i,
    input  logic       rst_n,
    input  logic [7:0] rx_data_i,
    input  logic       rx_valid_i,
    output logic [7:0] cmd_addr_o,
    output logic [7:0] cmd_data_o,
    output logic [1:0] cmd_opt_o,
    input  logic [7:0] cmd_rdata_i,
    output logic [7:0] tx_data_o,
    output logic       tx_valid_o,
    input  logic       tx_ready_i,
    output logic [7:0] err_cnt_o
);

    localparam logic [1:0] OptIdle  = 2'b00;
    localparam logic [1:0] OptWrite = 2'b01;
    localparam logic [1:0] OptRead  = 2'b10;
    localparam logic [7:0] OpWrite  = 8'h57;
    localparam logic [7:0] OpRead   = 8'h52;

    typedef enum logic [2:0] {
        StIdle, StOp, StAddr, StData, StChk, StIssue, StRwait, StResp
    } state_e;

    state_e      state_q;
    logic [7:0]  op_q;
    logic [7:0]  addr_q;
    logic [7:0]  data_q;
    logic [15:0] gap_q;
    logic [7:0]  err_q;
    logic [7:0]  cmd_addr_q;
    logic [7:0]  cmd_data_q;
    logic [1:0]  cmd_opt_q;
    logic [7:0]  tx_data_q;
    logic        tx_valid_q;

    logic in_frame;
    logic timeout;
    logic op_ok;
    logic chk_ok;
    logic bad_op;
    logic bad_chk;
    logic dropped;
    logic err_inc;

    // Decode error sources; they are merged so simultaneous events count once.
    always_comb begin
        in_frame = (state_q == StOp) || (state_q == StAddr) ||
                   (state_q == StData) || (state_q == StChk);
        timeout  = in_frame && !rx_valid_i && (gap_q == TIMEOUT_CYC - 16'd1);
        op_ok    = (rx_data_i == OpWrite) || (rx_data_i == OpRead);
        chk_ok   = ((op_q ^ addr_q ^ data_q) == rx_data_i);
        bad_op   = (state_q == StOp) && rx_valid_i && !op_ok;
        bad_chk  = (state_q == StChk) && rx_valid_i && !chk_ok;
        // Bytes arriving while a command is in flight are not buffered.
        dropped  = rx_valid_i && ((state_q == StIssue) || (state_q == StRwait) ||
                                  (state_q == StResp));
        err_inc  = timeout || bad_op || bad_chk || dropped;
    end

    // Frame FSM with registered command/response outputs, gap timer and error count.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            op_q       <= 8'h00;
            addr_q     <= 8'h00;
            data_q     <= 8'h00;
            gap_q      <= 16'h0000;
            err_q      <= 8'h00;
            cmd_addr_q <= 8'h00;
            cmd_data_q <= 8'h00;
            cmd_opt_q  <= OptIdle;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
        end else begin
            cmd_opt_q <= OptIdle;

            if (err_inc && (err_q != 8'hFF)) begin
                err_q <= err_q + 8'd1;
            end

            if (in_frame && !rx_valid_i && !timeout) begin
                gap_q <= gap_q + 16'd1;
            end else begin
                gap_q <= 16'h0000;
            end

            unique case (state_q)
                StIdle: begin
                    if (rx_valid_i && (rx_data_i == HDR)) begin
                        state_q <= StOp;
                    end
                end
                StOp: begin
                    if (timeout) begin
                        state_q <= StIdle;
                    end else if (rx_valid_i) begin
                        if (op_ok) begin
                            op_q    <= rx_data_i;
                            state_q <= StAddr;
                        end else begin
                            state_q <= StIdle;
                        end
                    end
                end
                StAddr: begin
                    if (timeout) begin
                        state_q <= StIdle;
                    end else if (rx_valid_i) begin
                        addr_q  <= rx_data_i;
                        state_q <= StData;
                    end
                end
                StData: begin
                    if (timeout) begin
                        state_q <= StIdle;
                    end else if (rx_valid_i) begin
                        data_q  <= rx_data_i;
                        state_q <= StChk;
                    end
                end
                StChk: begin
                    if (timeout) begin
                        state_q <= StIdle;
                    end else if (rx_valid_i) begin
                        if (chk_ok) begin
                            cmd_addr_q <= addr_q;
                            cmd_data_q <= data_q;
                            cmd_opt_q  <= (op_q == OpWrite) ? OptWrite : OptRead;
                            state_q    <= StIssue;
                        end else begin
                            tx_data_q  <= NAK;
                            tx_valid_q <= 1'b1;
                            state_q    <= StResp;
                        end
                    end
                end
                StIssue: begin
                    if (op_q == OpWrite) begin
                        tx_data_q  <= ACK;
                        tx_valid_q <= 1'b1;
                        state_q    <= StResp;
                    end else begin
                        state_q <= StRwait;
                    end
                end
                StRwait: begin
                    // Register block returns read data one cycle after the strobe.
                    tx_data_q  <= cmd_rdata_i;
                    tx_valid_q <= 1'b1;
                    state_q    <= StResp;
                end
                StResp: begin
                    if (tx_ready_i) begin
                        tx_valid_q <= 1'b0;
                        state_q    <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign cmd_addr_o = cmd_addr_q;
    assign cmd_data_o = cmd_data_q;
    assign cmd_opt_o  = cmd_opt_q;
    assign tx_data_o  = tx_data_q;
    assign tx_valid_o = tx_valid_q;
    assign err_cnt_o  = err_q;

endmodule
